iterative_muldiv_unit: RTL and testbench

- Multi-cycle RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU with a radix-2 iterative datapath, parametrised in XLEN.
- Uses a valid/ready request handshake and a valid/ready result handshake, so the core stalls on op_ready_o and result_valid_o.

---
 rtl/iterative_muldiv_unit_if.sv | 37 +++
 rtl/iterative_muldiv_unit.sv | 236 +++++++++++++++++++++++
 tb/tb_iterative_muldiv_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iterative_muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// iterative_muldiv_unit_if
//   Request/result handshake bundle for the iterative RV32M mul/div unit.
//
//   Request channel : op_valid_i / op_ready_o, op_sel_i (RV32M funct3),
//                     operand_a_i (rs1), operand_b_i (rs2), flush_i
//   Result channel  : result_valid_o / result_ready_i, result_o
//
//   Modports:
//     master - the execute stage issuing operations and consuming results
//     slave  - the mul/div unit itself
// ----------------------------------------------------------------------------
interface iterative_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            op_valid_i;
    logic            op_ready_o;
    logic [2:0]      op_sel_i;
    logic [XLEN-1:0] operand_a_i;
    logic [XLEN-1:0] operand_b_i;
    logic            flush_i;
    logic            result_valid_o;
    logic            result_ready_i;
    logic [XLEN-1:0] result_o;

    modport master (
        output op_valid_i, op_sel_i, operand_a_i, operand_b_i, flush_i,
               result_ready_i,
        input  op_ready_o, result_valid_o, result_o
    );

    modport slave (
        input  op_valid_i, op_sel_i, operand_a_i, operand_b_i, flush_i,
               result_ready_i,
        output op_ready_o, result_valid_o, result_o
    );
endinterface

// File: rtl/iterative_muldiv_unit.sv
// ----------------------------------------------------------------------------
// iterative_muldiv_unit
//   Multi-cycle RV32M multiply/divide unit for the execute stage. Executes
//   MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU using a radix-2
//   datapath: one shift-add (multiply) or one restoring shift-subtract
//   (divide) step per cycle, XLEN steps per operation.
//
//   Ports:
//     clk_i   - clock, rising edge
//     rst_ni  - asynchronous active-low reset
//     bus     - iterative_muldiv_unit_if.slave (request + result handshakes,
//               flush_i synchronous kill)
//
//   Operation:
//     IDLE : op_ready_o high; an accepted request captures funct3, operand
//            magnitudes and sign flags.
//     CALC : XLEN iteration steps; the last step loads result_o.
//     DONE : result_valid_o high; held until result_ready_i at an edge.
//   Divide by zero and signed overflow bypass CALC (result in 1 cycle).
//
//   Configuration macro:
//     MULDIV_FAST_MUL_EN - multiplies use a single-cycle 2*XLEN combinational
//                          multiplier and go straight to DONE; divides stay
//                          iterative. Undefined: no hardware multiplier.
// ----------------------------------------------------------------------------
module iterative_muldiv_unit #(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN + 1)
) (
    input logic                         clk_i,
    input logic                         rst_ni,
    iterative_muldiv_unit_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          sel_q;
    logic [XLEN-1:0]     opnd_q;     // multiplicand (mul) or divisor (div) magnitude
    logic [XLEN-1:0]     hi_q;       // product high half / partial remainder
    logic [XLEN-1:0]     lo_q;       // multiplier bits -> product low half / quotient
    logic                neg_res_q;  // negate product or quotient at the end
    logic                neg_rem_q;  // negate remainder at the end
    logic [XLEN-1:0]     result_q;

    // ------------------------------------------------------------------
    // Request decode (valid only while a request is presented)
    // ------------------------------------------------------------------
    logic [2:0]      sel;
    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_by_zero;
    logic            div_ovf;
    logic            div_special;
    logic [XLEN-1:0] special_res;

    assign sel      = bus.op_sel_i;
    assign is_div   = sel[2];
    // MULHSU: a signed, b unsigned. MULHU/DIVU/REMU: both unsigned.
    assign a_signed = is_div ? ~sel[0] : (sel[1:0] != 2'b11);
    assign b_signed = is_div ? ~sel[0] : ~sel[1];
    assign a_neg    = a_signed & bus.operand_a_i[XLEN-1];
    assign b_neg    = b_signed & bus.operand_b_i[XLEN-1];
    assign a_mag    = a_neg ? -bus.operand_a_i : bus.operand_a_i;
    assign b_mag    = b_neg ? -bus.operand_b_i : bus.operand_b_i;

    assign div_by_zero = is_div & (bus.operand_b_i == '0);
    assign div_ovf     = is_div & ~sel[0] & (bus.operand_a_i == MOST_NEG) &
                         (bus.operand_b_i == '1);
    assign div_special = div_by_zero | div_ovf;

    // sel[1] distinguishes REM/REMU from DIV/DIVU.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        special_res = '0;
        if (div_by_zero) begin
            special_res = sel[1] ? bus.operand_a_i : '1;
        end else if (div_ovf) begin
            special_res = sel[1] ? '0 : bus.operand_a_i;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    logic [2*XLEN-1:0] fast_prod_fix;
    logic [XLEN-1:0]   fast_res;

    assign fast_prod     = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    assign fast_prod_fix = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
    assign fast_res      = (sel == 3'b000) ? fast_prod_fix[XLEN-1:0]
                                           : fast_prod_fix[2*XLEN-1:XLEN];
`endif

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] step_hi;
    logic [XLEN-1:0] step_lo;

    // Multiply: add multiplicand when the current multiplier LSB is set, then
    // shift {carry, hi, lo} right; after XLEN steps {hi, lo} is the product.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: shift the next dividend bit into the partial remainder and try
    // subtracting the divisor; a clear borrow means the quotient bit is 1.
    assign rem_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = rem_shift - {1'b0, opnd_q};

    always_comb begin
        step_hi = hi_q;
        step_lo = lo_q;
        if (sel_q[2]) begin
            if (!div_diff[XLEN]) begin
                step_hi = div_diff[XLEN-1:0];
                step_lo = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                step_hi = rem_shift[XLEN-1:0];
                step_lo = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Sign fix-up applied to the final step's outcome
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    assign prod     = {step_hi, step_lo};
    assign prod_fix = neg_res_q ? -prod : prod;
    assign quo_fix  = neg_res_q ? -step_lo : step_lo;
    assign rem_fix  = neg_rem_q ? -step_hi : step_hi;

    always_comb begin
        final_res = '0;
        case (sel_q)
            3'b000:                 final_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo_fix;
            default:                final_res = rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: datapath registers are reset along with control so that
            // the result bus is deterministic after reset, not just the FSM.
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else if (bus.flush_i) begin
            // Flush wins over accept and result handshake; result_q kept.
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.op_valid_i) begin
                        sel_q     <= sel;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        cnt_q     <= '0;
                        if (div_special) begin
                            result_q <= special_res;
                            state_q  <= DONE;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!is_div) begin
                            result_q <= fast_res;
                            state_q  <= DONE;
                        end
`endif
                        else begin
                            hi_q    <= '0;
                            lo_q    <= is_div ? a_mag : b_mag;
                            opnd_q  <= is_div ? b_mag : a_mag;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        result_q <= final_res;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.result_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.op_ready_o     = (state_q == IDLE);
    assign bus.result_valid_o = (state_q == DONE);
    assign bus.result_o       = result_q;

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_iterative_muldiv_unit
//   Self-checking bench for iterative_muldiv_unit (XLEN = 32). Expected
//   results and latencies are pushed to a scoreboard queue when a request is
//   issued and popped when the unit presents its result.
// ----------------------------------------------------------------------------
module tb_iterative_muldiv_unit;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_ni;
    int   checks;
    int   failures;
    exp_t sb_q[$];
    logic [31:0] last_res;

    iterative_muldiv_unit_if #(.XLEN(XLEN)) bus ();

    iterative_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Independent reference using 64-bit arithmetic and SV truncating division.
    function automatic logic [31:0] ref_model(input logic [2:0] sel,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        int          ia;
        int          ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (sel)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] sel,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        if (sel[2] && (b == 0)) return 1;
        if (sel[2] && !sel[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))
            return 1;
        if (!sel[2] && FAST_MUL) return 1;
        return XLEN + 1;
    endfunction

    task automatic push_exp(input string tag, input logic [2:0] sel,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res);
        exp_t e;
        e.tag = tag;
        e.res = exp_res;
        e.lat = ref_latency(sel, a, b);
        sb_q.push_back(e);
    endtask

    // Present a request and hold it until accepted; returns at the negedge
    // after the accept edge.
    task automatic start_op(input logic [2:0] sel, input logic [31:0] a,
                            input logic [31:0] b);
        int wait_cyc;
        @(negedge clk);
        bus.op_valid_i  = 1'b1;
        bus.op_sel_i    = sel;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        wait_cyc = 0;
        while (!bus.op_ready_o && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (wait_cyc >= 50) check("accept_timeout", bus.op_ready_o, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.op_valid_i  = 1'b0;
        bus.operand_a_i = $urandom;
        bus.operand_b_i = $urandom;
    endtask

    task automatic issue(input string tag, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res);
        push_exp(tag, sel, a, b, exp_res);
        start_op(sel, a, b);
    endtask

    // Called at the negedge after the accept edge (latency 1 so far).
    task automatic collect(input bit take);
        int   lat;
        exp_t e;
        lat = 1;
        while (!bus.result_valid_o && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (lat >= 100) check("result_timeout", bus.result_valid_o, 1'b1);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check(e.tag, bus.result_o, e.res);
        check({e.tag, "_lat"}, 32'(lat), 32'(e.lat));
        last_res = e.res;
        if (take) begin
            bus.result_ready_i = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.result_ready_i = 1'b0;
            check({e.tag, "_idle"}, {31'b0, bus.op_ready_o}, 32'd1);
        end
    endtask

    initial begin
        logic        seen_valid;
        logic [2:0]  rsel;
        logic [31:0] ra;
        logic [31:0] rb;

        checks             = 0;
        failures           = 0;
        last_res           = '0;
        rst_ni             = 1'b0;
        bus.op_valid_i     = 1'b0;
        bus.op_sel_i       = '0;
        bus.operand_a_i    = '0;
        bus.operand_b_i    = '0;
        bus.flush_i        = 1'b0;
        bus.result_ready_i = 1'b0;

        #23;
        check("rst_result", bus.result_o, 32'h0);
        check("rst_valid", {31'b0, bus.result_valid_o}, 32'd0);
        check("rst_ready", {31'b0, bus.op_ready_o}, 32'd1);
        @(negedge clk);
        rst_ni = 1'b1;

        // Directed cases from the test plan.
        issue("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14);            collect(1);
        issue("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2);             collect(1);
        issue("mulh_m1_2", 3'b001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF); collect(1);
        issue("mulhu_m1_2", 3'b011, 32'hFFFF_FFFF, 32'd2, 32'h1);        collect(1);
        issue("mul_m1_2", 3'b000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);  collect(1);
        issue("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); collect(1);
        issue("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);   collect(1);
        issue("div_by0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);           collect(1);
        issue("rem_by0", 3'b110, 32'd5, 32'd0, 32'd5);                   collect(1);
        issue("div_m20_3", 3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA); collect(1);
        issue("rem_m20_3", 3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE); collect(1);
        issue("mulhsu_m3_big", 3'b010, 32'hFFFF_FFFD, 32'h8000_0001,
              ref_model(3'b010, 32'hFFFF_FFFD, 32'h8000_0001));          collect(1);
        issue("divu_by0", 3'b101, 32'd77, 32'd0, 32'hFFFF_FFFF);         collect(1);
        issue("remu_by0", 3'b111, 32'd77, 32'd0, 32'd77);                collect(1);

        // Back-pressure: result held, then a new request only after release.
        issue("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3);
        collect(0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("hold_res%0d", i), bus.result_o, 32'd3);
            check($sformatf("hold_rdy%0d", i), {31'b0, bus.op_ready_o}, 32'd0);
        end
        bus.result_ready_i = 1'b1;
        bus.op_valid_i     = 1'b1;
        bus.op_sel_i       = 3'b101;
        bus.operand_a_i    = 32'd100;
        bus.operand_b_i    = 32'd7;
        push_exp("divu_after_hold", 3'b101, 32'd100, 32'd7, 32'd14);
        @(posedge clk);
        @(negedge clk);
        bus.result_ready_i = 1'b0;
        check("release_idle", {31'b0, bus.op_ready_o}, 32'd1);
        check("release_novalid", {31'b0, bus.result_valid_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.op_valid_i = 1'b0;
        check("reaccept_busy", {31'b0, bus.op_ready_o}, 32'd0);
        collect(1);

        // Flush mid-CALC (divide stays iterative in every build).
        start_op(3'b101, 32'd1000, 32'd3);
        repeat (11) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_idle", {31'b0, bus.op_ready_o}, 32'd1);
        check("flush_novalid", {31'b0, bus.result_valid_o}, 32'd0);
        check("flush_res_kept", bus.result_o, last_res);
        seen_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen_valid |= bus.result_valid_o;
        end
        check("flush_never_valid", {31'b0, seen_valid}, 32'd0);

        // Asynchronous reset mid-CALC.
        start_op(3'b101, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_result", bus.result_o, 32'h0);
        check("arst_valid", {31'b0, bus.result_valid_o}, 32'd0);
        check("arst_ready", {31'b0, bus.op_ready_o}, 32'd1);
        @(negedge clk);
        rst_ni = 1'b1;
        issue("divu_after_rst", 3'b101, 32'd1000, 32'd3, 32'd333);
        collect(1);

        // Random operations against the reference model.
        for (int i = 0; i < 16; i++) begin
            rsel = 3'($urandom_range(0, 7));
            ra   = $urandom;
            rb   = $urandom;
            if (i % 5 == 0) rb = 32'd0;
            if (i % 7 == 3) rb = 32'($urandom_range(1, 20));
            issue($sformatf("rnd%0d_sel%0d", i, rsel), rsel, ra, rb,
                  ref_model(rsel, ra, rb));
            collect(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
